// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Turns semantic instruction requests (op, register indices, immediate) into
// 32-bit RV32I machine words with sequential instruction-memory addresses.
// Supported subset: ADD, SUB, ADDI, LW, SW, BEQ, JAL. Requests whose immediate
// cannot be encoded, and the reserved op, are consumed without producing a
// word; they set a sticky error flag and bump a saturating error counter.
// A small IDLE/RUN/DONE sequencer brackets one program. The program ends when
// the word flagged last leaves downstream, or when a last request is rejected.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   clear      pulse: back to IDLE, address to BASE_ADDR, errors cleared
//   in_valid / in_ready   request handshake
//   in_op      0=ADD 1=SUB 2=ADDI 3=LW 4=SW 5=BEQ 6=JAL 7=reserved
//   in_rd / in_rs1 / in_rs2   register indices (REG_ADDRW bits)
//   in_imm     signed byte immediate / offset
//   in_last    final request of a program
//   out_valid / out_ready   output handshake
//   out_word   encoded instruction
//   out_addr   write address of out_word
//   done       program complete (DONE state)
//   err        sticky, set by any rejected request
//   err_count  rejected-request count, saturating at 255
// -----------------------------------------------------------------------------
module instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          REG_ADDRW = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           in_op,
    input  logic [REG_ADDRW-1:0] in_rd,
    input  logic [REG_ADDRW-1:0] in_rs1,
    input  logic [REG_ADDRW-1:0] in_rs2,
    input  logic [31:0]          in_imm,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_word,
    output logic [31:0]          out_addr,
    output logic                 done,
    output logic                 err,
    output logic [7:0]           err_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_ADDI = 3'd2;
    localparam logic [2:0] OP_LW   = 3'd3;
    localparam logic [2:0] OP_SW   = 3'd4;
    localparam logic [2:0] OP_BEQ  = 3'd5;
    localparam logic [2:0] OP_JAL  = 3'd6;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Register indices are zero-extended into the 5-bit RISC-V fields.
    function automatic logic [4:0] reg_field(input logic [REG_ADDRW-1:0] idx);
        return 5'(idx);
    endfunction

    // Immediate range checks: the value must survive sign-extension from the
    // field width; branch/jump offsets must also be halfword aligned.
    function automatic logic is_legal(input logic [2:0] op, input logic [31:0] imm);
        logic i_ok;
        logic b_ok;
        logic j_ok;
        logic ok;
        i_ok = (imm[31:11] == {21{imm[11]}});
        b_ok = (imm[31:12] == {20{imm[12]}}) && (imm[0] == 1'b0);
        j_ok = (imm[31:20] == {12{imm[20]}}) && (imm[0] == 1'b0);
        case (op)
            OP_ADD, OP_SUB:        ok = 1'b1;
            OP_ADDI, OP_LW, OP_SW: ok = i_ok;
            OP_BEQ:                ok = b_ok;
            OP_JAL:                ok = j_ok;
            default:               ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Field packing per instruction format; unused fields stay zero.
    function automatic logic [31:0] encode(input logic [2:0] op, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2,
                                           input logic [31:0] imm);
        logic [31:0] w;
        case (op)
            OP_ADD:  w = {7'b0000000, rs2, rs1, 3'b000, rd, OPC_OP};
            OP_SUB:  w = {7'b0100000, rs2, rs1, 3'b000, rd, OPC_OP};
            OP_ADDI: w = {imm[11:0], rs1, 3'b000, rd, OPC_OPIMM};
            OP_LW:   w = {imm[11:0], rs1, 3'b010, rd, OPC_LOAD};
            OP_SW:   w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OPC_STORE};
            OP_BEQ:  w = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OPC_BRANCH};
            OP_JAL:  w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    state_t      state_r;
    state_t      state_n_s;
    logic        out_valid_r;
    logic [31:0] out_word_r;
    logic [31:0] out_addr_r;
    logic        out_last_r;
    logic [31:0] next_addr_r;
    logic        err_r;
    logic [7:0]  err_count_r;

    logic        in_ready_s;
    logic        accept_s;
    logic        legal_s;
    logic        reject_s;
    logic        out_hs_s;
    logic [31:0] word_s;

    // The output slot frees up in the same cycle it is drained, so ready only
    // depends on registered state and out_ready, never on in_valid.
    assign in_ready_s = (state_r != ST_DONE) && (!out_valid_r || out_ready);
    assign accept_s   = in_valid && in_ready_s;
    assign legal_s    = is_legal(in_op, in_imm);
    assign reject_s   = accept_s && !legal_s;
    assign out_hs_s   = out_valid_r && out_ready;
    assign word_s     = encode(in_op, reg_field(in_rd), reg_field(in_rs1),
                               reg_field(in_rs2), in_imm);

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_word  = out_word_r;
    assign out_addr  = out_addr_r;
    assign done      = (state_r == ST_DONE);
    assign err       = err_r;
    assign err_count = err_count_r;

    // Program sequencer state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Sequencer next state; clear overrides every other transition.
    always_comb begin
        state_n_s = state_r;
        if (clear) begin
            state_n_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (reject_s && in_last) begin
                        state_n_s = ST_DONE;
                    end else if (accept_s) begin
                        state_n_s = ST_RUN;
                    end else begin
                        state_n_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if ((out_hs_s && out_last_r) || (reject_s && in_last)) begin
                        state_n_s = ST_DONE;
                    end else begin
                        state_n_s = ST_RUN;
                    end
                end
                ST_DONE: state_n_s = ST_DONE;
                default: state_n_s = ST_IDLE;
            endcase
        end
    end

    // Output register, address counter and error bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_word_r  <= 32'h0000_0000;
            out_addr_r  <= BASE_ADDR;
            out_last_r  <= 1'b0;
            next_addr_r <= BASE_ADDR;
            err_r       <= 1'b0;
            err_count_r <= 8'd0;
        end else if (clear) begin
            out_valid_r <= 1'b0;
            out_word_r  <= 32'h0000_0000;
            out_addr_r  <= BASE_ADDR;
            out_last_r  <= 1'b0;
            next_addr_r <= BASE_ADDR;
            err_r       <= 1'b0;
            err_count_r <= 8'd0;
        end else begin
            if (accept_s && legal_s) begin
                out_valid_r <= 1'b1;
                out_word_r  <= word_s;
                out_addr_r  <= next_addr_r;
                out_last_r  <= in_last;
                next_addr_r <= next_addr_r + 32'd4;
            end else if (out_hs_s) begin
                out_valid_r <= 1'b0;
            end
            // A rejection may coincide with a downstream drain above.
            if (reject_s) begin
                err_r <= 1'b1;
                if (err_count_r != 8'hFF) begin
                    err_count_r <= err_count_r + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder
//
// Directed steps followed by a randomized phase. A behavioural model holds the
// expected output slot as a queue of {word, addr, last} entries, an address
// counter, an error count and a done flag; encodings and legality are derived
// from the instruction-format rules with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_instr_encoder;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [2:0]  in_rd;
    logic [2:0]  in_rs1;
    logic [2:0]  in_rs2;
    logic [31:0] in_imm;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [31:0] out_addr;
    logic        done;
    logic        err;
    logic [7:0]  err_count;

    instr_encoder #(.BASE_ADDR(BASE), .REG_ADDRW(3)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_addr(out_addr), .done(done),
        .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic [31:0] addr;
        bit          last;
    } ent_t;

    int          checks = 0;
    int          errors = 0;
    ent_t        q[$];
    logic [31:0] m_addr;
    int          m_errs;
    bit          m_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_legal(input int op, input int imm);
        case (op)
            0, 1:    return 1'b1;
            2, 3, 4: return (imm >= -2048) && (imm <= 2047);
            5:       return (imm >= -4096) && (imm <= 4094) && ((imm & 1) == 0);
            6:       return (imm >= -1048576) && (imm <= 1048574) && ((imm & 1) == 0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_word(input int op, input int rd, input int rs1,
                                             input int rs2, input int imm);
        logic [31:0] u;
        logic [31:0] r;
        logic [31:0] s1;
        logic [31:0] s2;
        u  = imm;
        r  = rd << 7;
        s1 = rs1 << 15;
        s2 = rs2 << 20;
        case (op)
            0: return s2 | s1 | r | 32'h33;
            1: return (32'h20 << 25) | s2 | s1 | r | 32'h33;
            2: return ((u & 32'hFFF) << 20) | s1 | r | 32'h13;
            3: return ((u & 32'hFFF) << 20) | s1 | (32'd2 << 12) | r | 32'h03;
            4: return (((u >> 5) & 32'h7F) << 25) | s2 | s1 | (32'd2 << 12)
                      | ((u & 32'h1F) << 7) | 32'h23;
            5: return (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) | s2 | s1
                      | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7) | 32'h63;
            6: return (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21)
                      | (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12) | r | 32'h6F;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        m_addr = BASE;
        m_errs = 0;
        m_done = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 3'd0; in_rd = 3'd0; in_rs1 = 3'd0; in_rs2 = 3'd0;
        in_imm = 32'd0; in_last = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock: drive, compare against the model, predict the edge, advance.
    task automatic cycle(input bit v, input int op, input int rd, input int rs1,
                         input int rs2, input int imm, input bit last,
                         input bit ordy, input bit clr);
        bit rdy;
        in_valid = v; in_op = op[2:0]; in_rd = rd[2:0]; in_rs1 = rs1[2:0];
        in_rs2 = rs2[2:0]; in_imm = imm; in_last = last; out_ready = ordy; clear = clr;
        #1;
        rdy = !m_done && (q.size() == 0 || ordy);
        chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("out_word", out_word, q[0].word);
            chk("out_addr", out_addr, q[0].addr);
        end
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("err", {31'd0, err}, {31'd0, m_errs != 0});
        chk("err_count", {24'd0, err_count}, m_errs);
        chk("in_ready", {31'd0, in_ready}, {31'd0, rdy});
        if (clr) begin
            model_reset();
        end else begin
            if (q.size() != 0 && ordy) begin
                if (q[0].last) m_done = 1'b1;
                void'(q.pop_front());
            end
            if (v && rdy) begin
                if (ref_legal(op, imm)) begin
                    q.push_back('{ref_word(op, rd, rs1, rs2, imm), m_addr, last});
                    m_addr = m_addr + 32'd4;
                end else begin
                    if (m_errs < 255) m_errs++;
                    if (last) m_done = 1'b1;
                end
            end
        end
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, 0, 0, 0, 0, 0, 1'b0, ordy, 1'b0);
    endtask

    int imm_tbl[12] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096,
                        -1048576, 1048574, 1048576, 3};

    initial begin
        int op;
        int imm;
        int sel;
        bit v;

        // Reset state
        do_reset();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_word", out_word, 32'd0);
        chk("rst_out_addr", out_addr, BASE);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_err_count", {24'd0, err_count}, 32'd0);

        // ADDI x1, x0, 5 with one-cycle latency
        cycle(1'b1, 2, 1, 0, 0, 5, 1'b0, 1'b1, 1'b0);
        chk("addi_word", out_word, 32'h00500093);
        chk("addi_addr", out_addr, 32'h0);
        idle(1'b1);

        // Back-to-back program ending in JAL with in_last
        do_reset();
        cycle(1'b1, 1, 3, 1, 2, 0, 1'b0, 1'b1, 1'b0);
        chk("sub_word", out_word, 32'h402081B3);
        chk("sub_addr", out_addr, 32'h0);
        cycle(1'b1, 4, 0, 1, 2, 8, 1'b0, 1'b1, 1'b0);
        chk("sw_word", out_word, 32'h0020A423);
        chk("sw_addr", out_addr, 32'h4);
        cycle(1'b1, 5, 0, 1, 2, -4, 1'b0, 1'b1, 1'b0);
        chk("beq_word", out_word, 32'hFE208EE3);
        chk("beq_addr", out_addr, 32'h8);
        cycle(1'b1, 6, 1, 0, 0, 8, 1'b1, 1'b1, 1'b0);
        chk("jal_word", out_word, 32'h008000EF);
        chk("jal_addr", out_addr, 32'hC);
        idle(1'b1);
        chk("done_after_last", {31'd0, done}, 32'd1);
        chk("ready_in_done", {31'd0, in_ready}, 32'd0);
        cycle(1'b1, 2, 1, 0, 0, 1, 1'b0, 1'b1, 1'b0);
        chk("no_accept_in_done", {31'd0, out_valid}, 32'd0);
        cycle(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b1);

        // Downstream stall with a second request pending
        cycle(1'b1, 0, 4, 5, 6, 0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 2, 2, 3, 0, -7, 1'b0, 1'b0, 1'b0);
            chk("stall_addr", out_addr, 32'h0);
        end
        cycle(1'b1, 2, 2, 3, 0, -7, 1'b0, 1'b1, 1'b0);
        chk("after_stall_addr", out_addr, 32'h4);

        // Rejected requests: range, alignment, reserved op
        cycle(1'b1, 2, 1, 1, 0, 4096, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 5, 0, 1, 2, 3, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 7, 1, 1, 1, 0, 1'b0, 1'b1, 1'b0);
        chk("err_set", {31'd0, err}, 32'd1);
        chk("err_count3", {24'd0, err_count}, 32'd3);
        chk("no_word_on_err", {31'd0, out_valid}, 32'd0);
        cycle(1'b1, 3, 5, 6, 0, -2048, 1'b0, 1'b1, 1'b0);
        chk("addr_after_err", out_addr, 32'h8);

        // clear concurrent with a downstream handshake
        cycle(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b1);
        chk("clr_out_valid", {31'd0, out_valid}, 32'd0);
        chk("clr_err_count", {24'd0, err_count}, 32'd0);
        chk("clr_done", {31'd0, done}, 32'd0);
        cycle(1'b1, 2, 7, 7, 0, 2047, 1'b0, 1'b1, 1'b0);
        chk("clr_base_addr", out_addr, BASE);

        // Rejected last request ends the program
        cycle(1'b1, 7, 0, 0, 0, 0, 1'b1, 1'b1, 1'b0);
        chk("rej_last_done", {31'd0, done}, 32'd1);
        cycle(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b1, 1'b1);

        // Reset while a word is held
        cycle(1'b1, 7, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 0, 1, 2, 3, 0, 1'b0, 1'b0, 1'b0);
        chk("held_before_rst", {31'd0, out_valid}, 32'd1);
        do_reset();
        chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst2_out_word", out_word, 32'd0);
        chk("rst2_out_addr", out_addr, BASE);
        chk("rst2_err", {31'd0, err}, 32'd0);
        chk("rst2_err_count", {24'd0, err_count}, 32'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            op  = int'($urandom_range(0, 7));
            sel = int'($urandom_range(0, 3));
            if (sel == 0)      imm = int'($urandom_range(0, 4095)) - 2048;
            else if (sel == 1) imm = imm_tbl[$urandom_range(0, 11)];
            else if (sel == 2) imm = (int'($urandom_range(0, 8191)) - 4096) & ~1;
            else               imm = int'($urandom());
            v = ($urandom_range(0, 3) != 0);
            cycle(v, op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), imm, 1'b0, ($urandom_range(0, 9) < 7), 1'b0);
        end
        for (int n = 0; n < 3; n++) idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
